// File: rtl/rob_if.sv
// Reorder buffer bus: four masked field-write ports, the bypass lookup
// ports, a random-access entry read and the free-entry count.
interface rob_if #(
  parameter int ROB_WIDTH                  = 3,
  parameter int DATA_SIZE                  = 32,
  parameter int PHYSICAL_ADDR_WIDTH        = 20,
  parameter int VIRTUAL_ADDR_WIDTH         = 32,
  parameter int INSTRUCTION_WIDTH          = 32,
  parameter int INSTRUCTION_REGISTER_WIDTH = 5,
  parameter int ROB_STATE_WIDTH            = 2,
  parameter int BYPASS_STATE_WIDTH         = 2,
  parameter int ROB_WRITE_ENABLE_WIDTH     = 5
);
  logic [ROB_WRITE_ENABLE_WIDTH-1:0] write_alu, write_lu, write_mul4, write_wb;
  logic [ROB_WIDTH-1:0]              tag_alu, tag_lu, tag_mul4, tag_wb;
  logic [ROB_STATE_WIDTH-1:0]        state_alu, state_lu, state_mul4, state_wb;
  logic [PHYSICAL_ADDR_WIDTH-1:0]    addr_alu, addr_lu, addr_mul4, addr_wb;
  logic [DATA_SIZE-1:0]              value_alu, value_lu, value_mul4, value_wb;
  logic [VIRTUAL_ADDR_WIDTH-1:0]     pc_alu, pc_lu, pc_mul4, pc_wb;
  logic [INSTRUCTION_WIDTH-1:0]      instr_alu, instr_lu, instr_mul4, instr_wb;

  logic [ROB_WIDTH-1:0]                  head, tail;
  logic [INSTRUCTION_REGISTER_WIDTH-1:0] rs, rt;
  logic [BYPASS_STATE_WIDTH-1:0]         rs_state, rt_state;
  logic [DATA_SIZE-1:0]                  rs_value, rt_value;

  logic [ROB_WIDTH-1:0]           tag_read;
  logic [ROB_STATE_WIDTH-1:0]     state_read;
  logic [PHYSICAL_ADDR_WIDTH-1:0] addr_read;
  logic [DATA_SIZE-1:0]           value_read;
  logic [VIRTUAL_ADDR_WIDTH-1:0]  pc_read;
  logic [INSTRUCTION_WIDTH-1:0]   instr_read;
  logic [ROB_WIDTH:0]             empty_entries;

  modport master (
    output write_alu, write_lu, write_mul4, write_wb,
    output tag_alu, tag_lu, tag_mul4, tag_wb,
    output state_alu, state_lu, state_mul4, state_wb,
    output addr_alu, addr_lu, addr_mul4, addr_wb,
    output value_alu, value_lu, value_mul4, value_wb,
    output pc_alu, pc_lu, pc_mul4, pc_wb,
    output instr_alu, instr_lu, instr_mul4, instr_wb,
    output head, tail, rs, rt, tag_read,
    input  rs_state, rt_state, rs_value, rt_value,
    input  state_read, addr_read, value_read, pc_read, instr_read, empty_entries
  );

  modport slave (
    input  write_alu, write_lu, write_mul4, write_wb,
    input  tag_alu, tag_lu, tag_mul4, tag_wb,
    input  state_alu, state_lu, state_mul4, state_wb,
    input  addr_alu, addr_lu, addr_mul4, addr_wb,
    input  value_alu, value_lu, value_mul4, value_wb,
    input  pc_alu, pc_lu, pc_mul4, pc_wb,
    input  instr_alu, instr_lu, instr_mul4, instr_wb,
    input  head, tail, rs, rt, tag_read,
    output rs_state, rt_state, rs_value, rt_value,
    output state_read, addr_read, value_read, pc_read, instr_read, empty_entries
  );
endinterface

// File: rtl/rob.sv
// Reorder buffer storage: circular entry array with four masked write ports,
// combinational entry read, register bypass search and free-entry count.
module rob #(
  parameter int ROB_WIDTH                  = 3,
  parameter int DATA_SIZE                  = 32,
  parameter int PHYSICAL_ADDR_WIDTH        = 20,
  parameter int VIRTUAL_ADDR_WIDTH         = 32,
  parameter int INSTRUCTION_WIDTH          = 32,
  parameter int INSTRUCTION_REGISTER_WIDTH = 5,
  parameter int ROB_STATE_WIDTH            = 2,
  parameter int BYPASS_STATE_WIDTH         = 2,
  parameter int ROB_WRITE_ENABLE_WIDTH     = 5
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  rob_if.slave   bus
);
  localparam int N     = 1 << ROB_WIDTH;
  localparam int NPORT = 4;

  localparam logic [ROB_STATE_WIDTH-1:0]    ST_EMPTY    = 2'd0;
  localparam logic [ROB_STATE_WIDTH-1:0]    ST_COMPLETE = 2'd2;
  localparam logic [BYPASS_STATE_WIDTH-1:0] BY_NONE     = 2'd0;
  localparam logic [BYPASS_STATE_WIDTH-1:0] BY_WAIT     = 2'd1;
  localparam logic [BYPASS_STATE_WIDTH-1:0] BY_AVAIL    = 2'd2;

  logic [ROB_STATE_WIDTH-1:0]     state_q [N];
  logic [ROB_STATE_WIDTH-1:0]     state_d [N];
  logic [PHYSICAL_ADDR_WIDTH-1:0] addr_q  [N];
  logic [PHYSICAL_ADDR_WIDTH-1:0] addr_d  [N];
  logic [DATA_SIZE-1:0]           value_q [N];
  logic [DATA_SIZE-1:0]           value_d [N];
  logic [VIRTUAL_ADDR_WIDTH-1:0]  pc_q    [N];
  logic [VIRTUAL_ADDR_WIDTH-1:0]  pc_d    [N];
  logic [INSTRUCTION_WIDTH-1:0]   instr_q [N];
  logic [INSTRUCTION_WIDTH-1:0]   instr_d [N];

  // Port index order is ALU, LU, MUL4, WB: ascending write priority.
  logic [ROB_WRITE_ENABLE_WIDTH-1:0] wr_mask  [NPORT];
  logic [ROB_WIDTH-1:0]              wr_tag   [NPORT];
  logic [ROB_STATE_WIDTH-1:0]        wr_state [NPORT];
  logic [PHYSICAL_ADDR_WIDTH-1:0]    wr_addr  [NPORT];
  logic [DATA_SIZE-1:0]              wr_value [NPORT];
  logic [VIRTUAL_ADDR_WIDTH-1:0]     wr_pc    [NPORT];
  logic [INSTRUCTION_WIDTH-1:0]      wr_instr [NPORT];

  assign wr_mask[0]  = bus.write_alu;
  assign wr_mask[1]  = bus.write_lu;
  assign wr_mask[2]  = bus.write_mul4;
  assign wr_mask[3]  = bus.write_wb;
  assign wr_tag[0]   = bus.tag_alu;
  assign wr_tag[1]   = bus.tag_lu;
  assign wr_tag[2]   = bus.tag_mul4;
  assign wr_tag[3]   = bus.tag_wb;
  assign wr_state[0] = bus.state_alu;
  assign wr_state[1] = bus.state_lu;
  assign wr_state[2] = bus.state_mul4;
  assign wr_state[3] = bus.state_wb;
  assign wr_addr[0]  = bus.addr_alu;
  assign wr_addr[1]  = bus.addr_lu;
  assign wr_addr[2]  = bus.addr_mul4;
  assign wr_addr[3]  = bus.addr_wb;
  assign wr_value[0] = bus.value_alu;
  assign wr_value[1] = bus.value_lu;
  assign wr_value[2] = bus.value_mul4;
  assign wr_value[3] = bus.value_wb;
  assign wr_pc[0]    = bus.pc_alu;
  assign wr_pc[1]    = bus.pc_lu;
  assign wr_pc[2]    = bus.pc_mul4;
  assign wr_pc[3]    = bus.pc_wb;
  assign wr_instr[0] = bus.instr_alu;
  assign wr_instr[1] = bus.instr_lu;
  assign wr_instr[2] = bus.instr_mul4;
  assign wr_instr[3] = bus.instr_wb;

  // Later ports overwrite earlier ones per field, giving WB the final say.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    value_d = value_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    for (int p = 0; p < NPORT; p++) begin
      if (wr_mask[p][0]) state_d[wr_tag[p]] = wr_state[p];
      if (wr_mask[p][1]) addr_d[wr_tag[p]]  = wr_addr[p];
      if (wr_mask[p][2]) value_d[wr_tag[p]] = wr_value[p];
      if (wr_mask[p][3]) pc_d[wr_tag[p]]    = wr_pc[p];
      if (wr_mask[p][4]) instr_d[wr_tag[p]] = wr_instr[p];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < N; i++) begin
        state_q[i] <= '0;
        addr_q[i]  <= '0;
        value_q[i] <= '0;
        pc_q[i]    <= '0;
        instr_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      value_q <= value_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign bus.state_read = state_q[bus.tag_read];
  assign bus.addr_read  = addr_q[bus.tag_read];
  assign bus.value_read = value_q[bus.tag_read];
  assign bus.pc_read    = pc_q[bus.tag_read];
  assign bus.instr_read = instr_q[bus.tag_read];

  logic [ROB_WIDTH:0] empty_cnt;

  always_comb begin
    empty_cnt = '0;
    for (int i = 0; i < N; i++) begin
      if (state_q[i] == ST_EMPTY) empty_cnt = empty_cnt + (ROB_WIDTH+1)'(1);
    end
  end

  assign bus.empty_entries = empty_cnt;

  logic [ROB_WIDTH-1:0]          win_len;
  logic [ROB_WIDTH-1:0]          idx;
  logic [BYPASS_STATE_WIDTH-1:0] rs_st, rt_st;
  logic [DATA_SIZE-1:0]          rs_val, rt_val;

  // Scan oldest to youngest so the last hit is the youngest producer.
  always_comb begin
    win_len = bus.tail - bus.head;
    idx     = '0;
    rs_st   = BY_NONE;
    rt_st   = BY_NONE;
    rs_val  = '0;
    rt_val  = '0;
    for (int i = 0; i < N; i++) begin
      idx = bus.head + ROB_WIDTH'(i);
      if ((ROB_WIDTH'(i) < win_len) && (state_q[idx] != ST_EMPTY)) begin
        if (instr_q[idx][24:20] == bus.rs) begin
          rs_st  = (state_q[idx] == ST_COMPLETE) ? BY_AVAIL : BY_WAIT;
          rs_val = (state_q[idx] == ST_COMPLETE) ? value_q[idx] : '0;
        end
        if (instr_q[idx][24:20] == bus.rt) begin
          rt_st  = (state_q[idx] == ST_COMPLETE) ? BY_AVAIL : BY_WAIT;
          rt_val = (state_q[idx] == ST_COMPLETE) ? value_q[idx] : '0;
        end
      end
    end
  end

  assign bus.rs_state = rs_st;
  assign bus.rt_state = rt_st;
  assign bus.rs_value = rs_val;
  assign bus.rt_value = rt_val;
endmodule

// File: tb/tb_rob.sv
// Directed and randomized check of the reorder buffer against an
// entry-array reference model that searches the window youngest-first.
module tb_rob;
  localparam int N = 8;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  rob_if bus ();
  rob dut (.clk_i(clk_i), .rst_ni(rst_ni), .bus(bus));

  logic [4:0]  w_mask  [4];
  logic [2:0]  w_tag   [4];
  logic [1:0]  w_state [4];
  logic [19:0] w_addr  [4];
  logic [31:0] w_value [4];
  logic [31:0] w_pc    [4];
  logic [31:0] w_instr [4];

  assign bus.write_alu  = w_mask[0];
  assign bus.write_lu   = w_mask[1];
  assign bus.write_mul4 = w_mask[2];
  assign bus.write_wb   = w_mask[3];
  assign bus.tag_alu    = w_tag[0];
  assign bus.tag_lu     = w_tag[1];
  assign bus.tag_mul4   = w_tag[2];
  assign bus.tag_wb     = w_tag[3];
  assign bus.state_alu  = w_state[0];
  assign bus.state_lu   = w_state[1];
  assign bus.state_mul4 = w_state[2];
  assign bus.state_wb   = w_state[3];
  assign bus.addr_alu   = w_addr[0];
  assign bus.addr_lu    = w_addr[1];
  assign bus.addr_mul4  = w_addr[2];
  assign bus.addr_wb    = w_addr[3];
  assign bus.value_alu  = w_value[0];
  assign bus.value_lu   = w_value[1];
  assign bus.value_mul4 = w_value[2];
  assign bus.value_wb   = w_value[3];
  assign bus.pc_alu     = w_pc[0];
  assign bus.pc_lu      = w_pc[1];
  assign bus.pc_mul4    = w_pc[2];
  assign bus.pc_wb      = w_pc[3];
  assign bus.instr_alu  = w_instr[0];
  assign bus.instr_lu   = w_instr[1];
  assign bus.instr_mul4 = w_instr[2];
  assign bus.instr_wb   = w_instr[3];

  logic [1:0]  m_state [N];
  logic [19:0] m_addr  [N];
  logic [31:0] m_value [N];
  logic [31:0] m_pc    [N];
  logic [31:0] m_instr [N];

  int compared   = 0;
  int mismatched = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      m_state[i] = '0; m_addr[i] = '0; m_value[i] = '0; m_pc[i] = '0; m_instr[i] = '0;
    end
  endtask

  // Ports applied ALU, LU, MUL4, WB so the higher-priority port lands last.
  task automatic model_write();
    for (int p = 0; p < 4; p++) begin
      if (w_mask[p][0]) m_state[w_tag[p]] = w_state[p];
      if (w_mask[p][1]) m_addr[w_tag[p]]  = w_addr[p];
      if (w_mask[p][2]) m_value[w_tag[p]] = w_value[p];
      if (w_mask[p][3]) m_pc[w_tag[p]]    = w_pc[p];
      if (w_mask[p][4]) m_instr[w_tag[p]] = w_instr[p];
    end
  endtask

  function automatic void ref_bypass(input logic [4:0] r, output logic [1:0] st,
                                     output logic [31:0] v);
    int len;
    int e;
    len = (int'(bus.tail) - int'(bus.head) + N) % N;
    st = 2'd0;
    v  = 32'd0;
    for (int k = 1; k <= len; k++) begin
      e = (int'(bus.tail) - k + N) % N;
      if (m_state[e] != 2'd0 && m_instr[e][24:20] == r) begin
        st = (m_state[e] == 2'd2) ? 2'd2 : 2'd1;
        v  = (m_state[e] == 2'd2) ? m_value[e] : 32'd0;
        return;
      end
    end
  endfunction

  task automatic check_all(input string ctx);
    logic [1:0]  est;
    logic [31:0] ev;
    int          cnt;
    int          t;
    t   = int'(bus.tag_read);
    cnt = 0;
    for (int i = 0; i < N; i++) if (m_state[i] == 2'd0) cnt++;
    chk({ctx, ".state_read"}, 64'(bus.state_read), 64'(m_state[t]));
    chk({ctx, ".addr_read"},  64'(bus.addr_read),  64'(m_addr[t]));
    chk({ctx, ".value_read"}, 64'(bus.value_read), 64'(m_value[t]));
    chk({ctx, ".pc_read"},    64'(bus.pc_read),    64'(m_pc[t]));
    chk({ctx, ".instr_read"}, 64'(bus.instr_read), 64'(m_instr[t]));
    chk({ctx, ".empty"},      64'(bus.empty_entries), 64'(cnt));
    ref_bypass(bus.rs, est, ev);
    chk({ctx, ".rs_state"}, 64'(bus.rs_state), 64'(est));
    chk({ctx, ".rs_value"}, 64'(bus.rs_value), 64'(ev));
    ref_bypass(bus.rt, est, ev);
    chk({ctx, ".rt_state"}, 64'(bus.rt_state), 64'(est));
    chk({ctx, ".rt_value"}, 64'(bus.rt_value), 64'(ev));
  endtask

  task automatic clear_writes();
    for (int p = 0; p < 4; p++) begin
      w_mask[p] = '0; w_tag[p] = '0; w_state[p] = '0; w_addr[p] = '0;
      w_value[p] = '0; w_pc[p] = '0; w_instr[p] = '0;
    end
  endtask

  task automatic set_write(input int p, input logic [4:0] mask, input logic [2:0] tag,
                           input logic [1:0] st, input logic [31:0] d, input logic [31:0] instr);
    w_mask[p] = mask; w_tag[p] = tag; w_state[p] = st;
    w_addr[p] = d[19:0]; w_value[p] = d; w_pc[p] = d; w_instr[p] = instr;
  endtask

  // One clock edge; the model takes the writes only when out of reset.
  task automatic cycle();
    @(posedge clk_i);
    if (rst_ni) model_write();
    #1;
    clear_writes();
    #1;
  endtask

  initial begin
    clear_writes();
    model_clear();
    bus.head = '0; bus.tail = '0; bus.rs = '0; bus.rt = '0; bus.tag_read = 3'd5;
    #12;
    check_all("reset");
    rst_ni = 1'b1;

    // ADD r0 <- r1 + r2 on ALU; other ports carry plain data words.
    set_write(0, 5'h1f, 3'd0, 2'd1, 32'd1, 32'h0000_8800);
    set_write(1, 5'h1f, 3'd1, 2'd1, 32'd2, 32'd2);
    set_write(2, 5'h1f, 3'd2, 2'd1, 32'd3, 32'd3);
    set_write(3, 5'h1f, 3'd3, 2'd1, 32'd4, 32'd4);
    bus.tag_read = 3'd3;
    cycle();
    check_all("all_ports");
    chk("all_ports.empty4", 64'(bus.empty_entries), 64'd4);

    set_write(3, 5'h01, 3'd3, 2'd0, 32'd10, 32'd10);
    cycle();
    check_all("wb_state_only");
    chk("wb_state_only.value", 64'(bus.value_read), 64'd4);

    bus.head = 3'd0; bus.tail = 3'd2; bus.rs = 5'd0; bus.rt = 5'd1;
    #1;
    check_all("bypass_busy");
    set_write(0, 5'h01, 3'd0, 2'd2, 32'd0, 32'd0);
    bus.tag_read = 3'd0;
    cycle();
    check_all("bypass_after_complete");
    bus.tail = 3'd1;
    #1;
    check_all("bypass_avail");
    chk("bypass_avail.rs_state", 64'(bus.rs_state), 64'd2);
    chk("bypass_avail.rs_value", 64'(bus.rs_value), 64'd1);

    set_write(0, 5'h1f, 3'd5, 2'd1, 32'd7, 32'd7);
    set_write(3, 5'h1f, 3'd5, 2'd2, 32'd9, 32'd9);
    bus.tag_read = 3'd5;
    cycle();
    check_all("same_tag");
    chk("same_tag.value", 64'(bus.value_read), 64'd9);

    // Window wraps past the end of the array: entries 6, 7, 0.
    set_write(0, 5'h1f, 3'd6, 2'd2, 32'h66, 32'h0040_0000);
    set_write(1, 5'h1f, 3'd0, 2'd2, 32'hAA, 32'h0040_0000);
    set_write(2, 5'h1f, 3'd1, 2'd1, 32'hBB, 32'h0040_0000);
    set_write(3, 5'h01, 3'd7, 2'd0, 32'd0, 32'd0);
    bus.head = 3'd6; bus.tail = 3'd1; bus.rs = 5'd4; bus.rt = 5'd0;
    cycle();
    check_all("wrap");
    chk("wrap.rs_value", 64'(bus.rs_value), 64'hAA);

    repeat (400) begin
      for (int p = 0; p < 4; p++) begin
        logic [31:0] ins;
        ins = $urandom;
        ins[24:20] = 5'($urandom_range(0, 3));
        set_write(p, ($urandom_range(0, 2) == 0) ? 5'h00 : 5'($urandom),
                  3'($urandom), 2'($urandom), $urandom, ins);
      end
      bus.head = 3'($urandom); bus.tail = 3'($urandom);
      bus.rs = 5'($urandom_range(0, 3)); bus.rt = 5'($urandom_range(0, 3));
      bus.tag_read = 3'($urandom);
      cycle();
      check_all("random");
    end

    for (int t = 0; t < N; t += 4) begin
      for (int p = 0; p < 4; p++) set_write(p, 5'h1f, 3'(t + p), 2'd1, 32'h5A, 32'h0010_0000);
      cycle();
    end
    bus.head = 3'd2; bus.tail = 3'd7; bus.rs = 5'd1; bus.rt = 5'd1; bus.tag_read = 3'd4;
    for (int p = 0; p < 4; p++) set_write(p, 5'h1f, 3'(p), 2'd2, 32'h77, 32'h0010_0000);
    #1;
    check_all("pre_reset");
    rst_ni = 1'b0;
    #1;
    model_clear();
    check_all("async_reset");
    chk("async_reset.empty8", 64'(bus.empty_entries), 64'd8);
    cycle();
    check_all("reset_hold");
    #3;
    rst_ni = 1'b1;
    set_write(2, 5'h1f, 3'd4, 2'd2, 32'h31, 32'h0010_0000);
    cycle();
    check_all("after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
